// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter (CPU vs debug port).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_CPU  = 2'd1,
    RESP_DBG  = 2'd2
  } resp_state_t;

  localparam int DMEM_ARB_CNT_W = 32;

  function automatic logic [DMEM_ARB_CNT_W-1:0] sat_inc(input logic [DMEM_ARB_CNT_W-1:0] v);
    return (v == {DMEM_ARB_CNT_W{1'b1}}) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Counts consecutive cycles the debug port loses arbitration; flags starvation at STARVE_LIMIT.
module dmem_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic starved
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_r;

  // Clear on grant or idle debug, otherwise count losses up to the limit without wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!dbg_req || dbg_gnt) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != LIMIT_C) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign starved = (cnt_r == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: CPU has fixed priority, debug gets a forced grant when starved.
// Optional perf counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [DMEM_ARB_CNT_W-1:0] perf_cpu_stall_cyc,
  output logic [DMEM_ARB_CNT_W-1:0] perf_dbg_grants
`endif
);

  logic        starved_s;
  logic        cpu_gnt_s;
  logic        dbg_gnt_s;
  resp_state_t state_r;

  dmem_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .reset   (reset),
    .dbg_req (dbg_req),
    .dbg_gnt (dbg_gnt_s),
    .starved (starved_s)
  );

  // Grant decision and memory port mux; the idle port drives all zeros
  always_comb begin
    dbg_gnt_s = dbg_req & (~cpu_req | starved_s);
    cpu_gnt_s = cpu_req & ~dbg_gnt_s;
    mem_en    = cpu_gnt_s | dbg_gnt_s;
    if (dbg_gnt_s) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt_s) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_WIDTH{1'b0}};
      mem_wdata = {DATA_WIDTH{1'b0}};
    end
  end

  assign dbg_gnt   = dbg_gnt_s;
  assign cpu_stall = cpu_req & ~cpu_gnt_s;

  // Response owner for next cycle's mem_rdata; writes produce no response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RESP_NONE;
    end else if (cpu_gnt_s && !cpu_we) begin
      state_r <= RESP_CPU;
    end else if (dbg_gnt_s && !dbg_we) begin
      state_r <= RESP_DBG;
    end else begin
      state_r <= RESP_NONE;
    end
  end

  assign cpu_rvalid = (state_r == RESP_CPU);
  assign dbg_rvalid = (state_r == RESP_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : {DATA_WIDTH{1'b0}};
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : {DATA_WIDTH{1'b0}};

`ifdef DMEM_ARB_PERF_EN
  // Saturating event counters for stall cycles and debug grants
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cpu_stall_cyc <= {DMEM_ARB_CNT_W{1'b0}};
      perf_dbg_grants    <= {DMEM_ARB_CNT_W{1'b0}};
    end else begin
      perf_cpu_stall_cyc <= cpu_stall ? sat_inc(perf_cpu_stall_cyc) : perf_cpu_stall_cyc;
      perf_dbg_grants    <= dbg_gnt_s ? sat_inc(perf_dbg_grants) : perf_dbg_grants;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural arbitration and memory model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = 32'd0, dbg_wdata = 32'd0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_stall_cyc, perf_dbg_grants;
`endif

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
`ifdef DMEM_ARB_PERF_EN
    .perf_cpu_stall_cyc (perf_cpu_stall_cyc),
    .perf_dbg_grants    (perf_dbg_grants),
`endif
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dbg_q[$];
  logic [31:0] tb_mem[64];
  logic [31:0] ref_mem[64];
  int          checks = 0, errors = 0, cyc = 0;
  int          starve_m = 0, stall_m = 0, dgnt_m = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory behind the arbiter; random data when not reading
  always @(posedge clk) begin
    if (mem_en && mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr[7:2]];
    else mem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One arbitration cycle: drive, compare combinational outputs with the model, queue responses
  task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                      input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                      output logic cg, output logic dg);
    logic [5:0] ci, di;
    @(posedge clk);
    #1;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    dg = dreq && (!creq || starve_m == LIMIT);
    cg = creq && !dg;
    ci = caddr[7:2];
    di = daddr[7:2];
    #3;
    chk("dbg_gnt", dbg_gnt, dg);
    chk("cpu_stall", cpu_stall, creq && !cg);
    chk("mem_en", mem_en, cg || dg);
    chk("mem_we", mem_we, dg ? dwe : (cg ? cwe : 1'b0));
    chk("mem_addr", mem_addr, dg ? daddr : (cg ? caddr : 32'd0));
    chk("mem_wdata", mem_wdata, dg ? dwd : (cg ? cwd : 32'd0));
    if (cg) begin
      if (cwe) ref_mem[ci] = cwd;
      else cpu_q.push_back('{cyc + 1, ref_mem[ci]});
    end
    if (dg) begin
      if (dwe) ref_mem[di] = dwd;
      else dbg_q.push_back('{cyc + 1, ref_mem[di]});
    end
    if (!dreq || dg) starve_m = 0;
    else if (starve_m < LIMIT) starve_m++;
    if (creq && !cg) stall_m++;
    if (dg) dgnt_m++;
  endtask

  task automatic idle(output logic cg, output logic dg);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, cg, dg);
  endtask

  // Response monitor: each rvalid must match the head of its queue on the due cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_resp cycle %0d got unexpected rvalid data %h expected none", cyc, cpu_rdata);
        end else begin
          e = cpu_q.pop_front();
          chk("cpu_resp_cycle", cyc, e.due);
          chk("cpu_rdata", cpu_rdata, e.data);
        end
      end else begin
        chk("cpu_rdata_idle", cpu_rdata, 32'd0);
        if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
          checks++; errors++;
          $display("FAIL cpu_resp cycle %0d got no rvalid expected data %h", cyc, cpu_q[0].data);
          e = cpu_q.pop_front();
        end
      end
      if (dbg_rvalid) begin
        if (dbg_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dbg_resp cycle %0d got unexpected rvalid data %h expected none", cyc, dbg_rdata);
        end else begin
          e = dbg_q.pop_front();
          chk("dbg_resp_cycle", cyc, e.due);
          chk("dbg_rdata", dbg_rdata, e.data);
        end
      end else begin
        chk("dbg_rdata_idle", dbg_rdata, 32'd0);
        if (dbg_q.size() != 0 && dbg_q[0].due <= cyc) begin
          checks++; errors++;
          $display("FAIL dbg_resp cycle %0d got no rvalid expected data %h", cyc, dbg_q[0].data);
          e = dbg_q.pop_front();
        end
      end
    end
  end

  initial begin
    logic        cg, dg;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wd, d_addr, d_wd, v;
    logic [5:0]  wi;

    for (int k = 0; k < 64; k++) begin
      v = $urandom;
      tb_mem[k] = v;
      ref_mem[k] = v;
    end
    tb_mem[24] = 32'd7;
    ref_mem[24] = 32'd7;

    // Reset state
    repeat (2) @(posedge clk);
    #4;
    chk("rst_cpu_stall", cpu_stall, 1'b0);
    chk("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Both ports requesting continuously: debug wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h60, 32'd0, 1'b1, 1'b0, 32'h64, 32'd0, cg, dg);
      chk("starve_pattern", dbg_gnt, (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    idle(cg, dg);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_dbg_grants_s3", perf_dbg_grants, 32'd2);
    chk("perf_cpu_stall_s3", perf_cpu_stall_cyc, 32'd2);
`endif

    // CPU load of a known word
    step(1'b1, 1'b0, 32'h60, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, cg, dg);
    idle(cg, dg);
    chk("s1_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("s1_cpu_rdata", cpu_rdata, 32'd7);

    // Debug write then read back
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h64, 32'd25, cg, dg);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h64, 32'd0, cg, dg);
    idle(cg, dg);
    chk("s2_dbg_rvalid", dbg_rvalid, 1'b1);
    chk("s2_dbg_rdata", dbg_rdata, 32'd25);

    // CPU store then load of the same address on consecutive cycles
    step(1'b1, 1'b1, 32'h60, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, cg, dg);
    step(1'b1, 1'b0, 32'h60, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, cg, dg);
    idle(cg, dg);
    chk("s4_cpu_rdata", cpu_rdata, 32'd7);
    idle(cg, dg);

    // Random traffic; stalled CPU and ungranted debug hold their fields
    c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0;
    c_addr = 32'd0; d_addr = 32'd0; c_wd = 32'd0; d_wd = 32'd0;
    cg = 1'b0; dg = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!(c_req && !cg)) begin
        c_req = ($urandom_range(0, 9) < ((i < 300) ? 9 : 5));
        c_we = 1'($urandom_range(0, 1));
        wi = 6'($urandom_range(0, 63));
        c_addr = {24'd0, wi, 2'b00};
        c_wd = $urandom;
      end
      if (!(d_req && !dg)) begin
        d_req = ($urandom_range(0, 9) < 5);
        d_we = 1'($urandom_range(0, 1));
        wi = 6'($urandom_range(0, 63));
        d_addr = {24'd0, wi, 2'b00};
        d_wd = $urandom;
      end
      step(c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd, cg, dg);
    end
    idle(cg, dg);
    idle(cg, dg);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_dbg_grants", perf_dbg_grants, dgnt_m);
    chk("perf_cpu_stall", perf_cpu_stall_cyc, stall_m);
`endif

    // Reset asserted in the grant cycle of a debug read drops the response
    @(posedge clk);
    #1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h64;
    #3;
    chk("s5_dbg_gnt", dbg_gnt, 1'b1);
    reset = 1'b1;
    starve_m = 0; stall_m = 0; dgnt_m = 0;
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    #3;
    chk("s5_dbg_rvalid", dbg_rvalid, 1'b0);
    chk("s5_dbg_rdata", dbg_rdata, 32'd0);
`ifdef DMEM_ARB_PERF_EN
    chk("s5_perf_dbg", perf_dbg_grants, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 32'h60, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, cg, dg);
    idle(cg, dg);
    chk("s5_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("s5_cpu_rdata", cpu_rdata, ref_mem[24]);
    idle(cg, dg);

    chk("cpu_q_drained", cpu_q.size(), 32'd0);
    chk("dbg_q_drained", dbg_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
